jk_cmd_driver: RTL and testbench



---
 rtl/jk_pkg.sv | 33 +++
 rtl/jk_cmd_fifo.sv | 68 ++++++
 rtl/jk_cmd_driver.sv | 161 ++++++++++++++++
 tb/tb_jk_cmd_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop command driver.
// Holds the command opcode encoding, the driver FSM state encoding and the
// helper that predicts the flip-flop output after a command.
package jk_pkg;

    // Command opcodes as carried on cmd_op
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_RESET  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    // Driver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10,
        ST_DWELL = 2'b11
    } jk_state_t;

    // Value q must take after the flip-flop has seen one command pulse
    function automatic logic expected_q(input logic [1:0] op, input logic q_prev);
        logic result;
        case (op)
            OP_SET:    result = 1'b1;
            OP_RESET:  result = 1'b0;
            OP_TOGGLE: result = ~q_prev;
            OP_HOLD:   result = q_prev;
            default:   result = q_prev;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits.
// Ports:
//   clk, rstn        clock and asynchronous active-low reset (clears pointers/count)
//   push, din        write request and data; ignored while full
//   pop, dout        read request and head-of-queue data; pop ignored while empty
//   full, empty      occupancy flags derived from the registered count
//   count            number of stored entries (0..DEPTH)
module jk_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CNTW-1:0] count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_r == CNTW'(DEPTH));
    assign empty     = (count_r == CNTW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array write; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// Command driver for a JK flip-flop.
// Queues set/reset/toggle/hold commands, turns each into a one-cycle j/k
// pulse, checks the flip-flop's q afterwards and waits a per-command dwell.
// Ports:
//   clk, rstn            clock and asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; ready is simply "FIFO not full"
//   cmd_op, cmd_dwell    opcode and post-check idle cycles
//   j, k                 registered pulses to the flip-flop
//   q_fb                 flip-flop q feedback
//   busy                 FSM active or commands still queued
//   err, err_clr         sticky q mismatch flag and its synchronous clear
//   done_cnt             wrapping count of completed commands
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_dwell,
    output logic          j,
    output logic          k,
    input  logic          q_fb,
    output logic          busy,
    output logic          err,
    input  logic          err_clr,
    output logic [CW-1:0] done_cnt
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    jk_state_t        state_r, state_nxt_s;
    logic [1:0]       op_r, op_nxt_s;
    logic [DW-1:0]    dwell_r, dwell_nxt_s;
    logic [DW-1:0]    dwell_cnt_r, dwell_cnt_nxt_s;
    logic             q_prev_r, q_prev_nxt_s;
    logic             j_r, j_nxt_s;
    logic             k_r, k_nxt_s;
    logic             err_r, err_nxt_s;
    logic [CW-1:0]    done_r, done_nxt_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CNTW-1:0]  count_s;
    logic [DW+1:0]    head_s;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (DW + 2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cmd_valid),
        .din   ({cmd_op, cmd_dwell}),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign cmd_ready = !full_s;
    assign busy      = (state_r != ST_IDLE) || (count_s != CNTW'(0));
    assign j         = j_r;
    assign k         = k_r;
    assign err       = err_r;
    assign done_cnt  = done_r;

    // Next-state, j/k pulse generation, q check and dwell countdown
    always_comb begin
        state_nxt_s     = state_r;
        op_nxt_s        = op_r;
        dwell_nxt_s     = dwell_r;
        dwell_cnt_nxt_s = dwell_cnt_r;
        q_prev_nxt_s    = q_prev_r;
        j_nxt_s         = 1'b0;
        k_nxt_s         = 1'b0;
        done_nxt_s      = done_r;
        pop_s           = 1'b0;
        if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    op_nxt_s     = head_s[DW+1:DW];
                    dwell_nxt_s  = head_s[DW-1:0];
                    q_prev_nxt_s = q_fb;
                    // Opcode bit 0 maps to J and bit 1 to K
                    j_nxt_s      = head_s[DW];
                    k_nxt_s      = head_s[DW+1];
                    state_nxt_s  = ST_DRIVE;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_nxt_s = ST_CHECK;
            end
            ST_CHECK: begin
                // A mismatch set outranks a clear in the same cycle
                if (q_fb != expected_q(op_r, q_prev_r)) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_nxt_s;
                end
                done_nxt_s = done_r + CW'(1);
                if (dwell_r == {DW{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    dwell_cnt_nxt_s = dwell_r;
                    state_nxt_s     = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (dwell_cnt_r == DW'(1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    dwell_cnt_nxt_s = dwell_cnt_r - DW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_HOLD;
            dwell_r     <= {DW{1'b0}};
            dwell_cnt_r <= {DW{1'b0}};
            q_prev_r    <= 1'b0;
            j_r         <= 1'b0;
            k_r         <= 1'b0;
            err_r       <= 1'b0;
            done_r      <= {CW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            op_r        <= op_nxt_s;
            dwell_r     <= dwell_nxt_s;
            dwell_cnt_r <= dwell_cnt_nxt_s;
            q_prev_r    <= q_prev_nxt_s;
            j_r         <= j_nxt_s;
            k_r         <= k_nxt_s;
            err_r       <= err_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flip-flop on j/k/q.
// done_cnt is built 4 bits wide so the wrap can be reached with 17 commands.
module tb_jk_cmd_driver;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_dwell;
    logic          j;
    logic          k;
    logic          q_fb;
    logic          busy;
    logic          err;
    logic          err_clr;
    logic [CW-1:0] done_cnt;

    logic          ff_q;
    logic          force_q0;
    int            cyc = 0;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            pulse_cyc[$];
    logic [1:0]    pulse_jk[$];
    logic          qhist[0:4095];
    int            waited;
    int            wsum;

    jk_cmd_driver #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dwell (cmd_dwell),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    // Reference JK flip-flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ff_q <= 1'b0;
        else if (j && k) ff_q <= ~ff_q;
        else if (j) ff_q <= 1'b1;
        else if (k) ff_q <= 1'b0;
        else ff_q <= ff_q;
    end

    assign q_fb = force_q0 ? 1'b0 : ff_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and q history sampled mid-cycle
    always @(negedge clk) begin
        if (cyc < 4096) qhist[cyc] = ff_q;
        if (rstn && (j || k)) begin
            pulse_cyc.push_back(cyc);
            pulse_jk.push_back({j, k});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and keep cmd_valid high afterwards; reports cycles spent waiting
    task automatic send(input logic [1:0] op, input logic [DW-1:0] dw, output int nwait);
        bit acc;
        acc = 1'b0;
        nwait = 0;
        cmd_op = op;
        cmd_dwell = dw;
        cmd_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (cmd_ready) begin
                step();
                acc = 1'b1;
                break;
            end
            nwait++;
            step();
        end
        check("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            if (!busy) break;
            step();
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_dwell = 8'd0;
        err_clr = 1'b0;
        force_q0 = 1'b0;
        #12;
        check("rst_j", {31'd0, j}, 32'd0);
        check("rst_k", {31'd0, k}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        step();
        rstn = 1'b1;
        step();

        // Four SETs with long dwell: one in the FSM, three queued, then reset
        cmd_op = 2'b01;
        cmd_dwell = 8'd20;
        cmd_valid = 1'b1;
        repeat (4) step();
        cmd_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_j", {31'd0, j}, 32'd0);
        check("arst_k", {31'd0, k}, 32'd0);
        check("arst_ready", {31'd0, cmd_ready}, 32'd1);
        check("arst_done", {28'd0, done_cnt}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        step();
        rstn = 1'b1;
        pulse_cyc.delete();
        pulse_jk.delete();
        repeat (10) step();
        check("no_pulse_after_rst", pulse_cyc.size(), 32'd0);

        // Reset during DRIVE drops j immediately and counts nothing
        cmd_op = 2'b01;
        cmd_dwell = 8'd0;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("drive_j", {31'd0, j}, 32'd1);
        rstn = 1'b0;
        #1;
        check("drive_rst_j", {31'd0, j}, 32'd0);
        step();
        rstn = 1'b1;
        repeat (4) step();
        check("drive_rst_done", {28'd0, done_cnt}, 32'd0);
        pulse_cyc.delete();
        pulse_jk.delete();

        // Basic sequence SET, TOGGLE, TOGGLE, RESET, HOLD with dwell 0
        send(2'b01, 8'd0, waited);
        send(2'b11, 8'd0, waited);
        send(2'b11, 8'd0, waited);
        send(2'b10, 8'd0, waited);
        send(2'b00, 8'd0, waited);
        cmd_valid = 1'b0;
        wait_idle();
        check("basic_npulse", pulse_cyc.size(), 32'd4);
        if (pulse_cyc.size() == 4) begin
            check("basic_jk0", {30'd0, pulse_jk[0]}, 32'h2);
            check("basic_jk1", {30'd0, pulse_jk[1]}, 32'h3);
            check("basic_jk2", {30'd0, pulse_jk[2]}, 32'h3);
            check("basic_jk3", {30'd0, pulse_jk[3]}, 32'h1);
            check("basic_gap1", pulse_cyc[1] - pulse_cyc[0], 32'd3);
            check("basic_gap2", pulse_cyc[2] - pulse_cyc[1], 32'd3);
            check("basic_gap3", pulse_cyc[3] - pulse_cyc[2], 32'd3);
            check("basic_q0", {31'd0, qhist[pulse_cyc[0] + 1]}, 32'd1);
            check("basic_q1", {31'd0, qhist[pulse_cyc[1] + 1]}, 32'd0);
            check("basic_q2", {31'd0, qhist[pulse_cyc[2] + 1]}, 32'd1);
            check("basic_q3", {31'd0, qhist[pulse_cyc[3] + 1]}, 32'd0);
            check("basic_q4", {31'd0, qhist[pulse_cyc[3] + 4]}, 32'd0);
        end
        check("basic_done", {28'd0, done_cnt}, 32'd5);
        check("basic_err", {31'd0, err}, 32'd0);
        pulse_cyc.delete();
        pulse_jk.delete();

        // Dwell: SET with dwell 5, then RESET
        send(2'b01, 8'd5, waited);
        send(2'b10, 8'd0, waited);
        cmd_valid = 1'b0;
        wait_idle();
        check("dwell_npulse", pulse_cyc.size(), 32'd2);
        if (pulse_cyc.size() == 2) check("dwell_gap", pulse_cyc[1] - pulse_cyc[0], 32'd8);
        check("dwell_q", {31'd0, ff_q}, 32'd0);
        check("dwell_done", {28'd0, done_cnt}, 32'd7);
        pulse_cyc.delete();
        pulse_jk.delete();

        // FIFO full: first command dwells 20 cycles while five more arrive
        wsum = 0;
        send(2'b01, 8'd20, waited);
        send(2'b10, 8'd0, waited); wsum += waited;
        send(2'b11, 8'd0, waited); wsum += waited;
        send(2'b01, 8'd0, waited); wsum += waited;
        send(2'b11, 8'd0, waited); wsum += waited;
        check("full_first5_nowait", wsum, 32'd0);
        check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
        send(2'b10, 8'd0, waited);
        check("full_wait", waited, 32'd20);
        cmd_valid = 1'b0;
        wait_idle();
        check("full_npulse", pulse_cyc.size(), 32'd6);
        if (pulse_cyc.size() == 6) begin
            check("full_jk0", {30'd0, pulse_jk[0]}, 32'h2);
            check("full_jk1", {30'd0, pulse_jk[1]}, 32'h1);
            check("full_jk2", {30'd0, pulse_jk[2]}, 32'h3);
            check("full_jk3", {30'd0, pulse_jk[3]}, 32'h2);
            check("full_jk4", {30'd0, pulse_jk[4]}, 32'h3);
            check("full_jk5", {30'd0, pulse_jk[5]}, 32'h1);
        end
        check("full_done", {28'd0, done_cnt}, 32'd13);
        check("full_err", {31'd0, err}, 32'd0);

        // Mismatch: q_fb held low across a SET
        force_q0 = 1'b1;
        send(2'b01, 8'd0, waited);
        cmd_valid = 1'b0;
        wait_idle();
        check("mm_err", {31'd0, err}, 32'd1);
        check("mm_done", {28'd0, done_cnt}, 32'd14);
        // Second mismatch with err_clr during its CHECK cycle
        send(2'b01, 8'd0, waited);
        cmd_valid = 1'b0;
        step();
        check("mm2_drive_j", {31'd0, j}, 32'd1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("mm2_err_priority", {31'd0, err}, 32'd1);
        force_q0 = 1'b0;
        wait_idle();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("errclr", {31'd0, err}, 32'd0);
        check("mm2_done", {28'd0, done_cnt}, 32'd15);

        // Counter wrap: 17 HOLDs from reset with a 4-bit counter
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        for (int i = 0; i < 17; i++) send(2'b00, 8'd0, waited);
        cmd_valid = 1'b0;
        wait_idle();
        check("wrap_done", {28'd0, done_cnt}, 32'd1);
        check("wrap_err", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
